dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Data-cache responder answering the multi-cycle CPU control FSM's MemRead/MemWrite/BE requests
//  with Cache_RDY/Cache_VALID. Direct-mapped, write-through, no-write-allocate, read-allocate.
//  Sits between the CPU datapath and the main-memory port; on a read miss it refills one line via sequential word reads.
// PARAMETERS
//  ADDR_W      12  byte-address width; ADDR[1:0] ignored (word access only)
//  NUM_LINES   8   cache lines, power of two; index = ADDR[2+OFF_W +: IDX_W]
//  LINE_WORDS  4   32-bit words per line, power of two; offset = ADDR[2 +: OFF_W]
//  (derived) tag = ADDR[ADDR_W-1 : 2+OFF_W+IDX_W], 5 bits at defaults
// PORTS
//  CLK          in   1       clock, all state on rising edge
//  RST          in   1       synchronous, active-high reset
//  MemRead      in   1       read request when MemWrite=0
//  MemWrite     in   1       write request (MemRead don't-care)
//  ADDR         in   ADDR_W  request byte address
//  WDATA        in   32      store data
//  BE           in   4       store byte enables; ignored on reads
//  Cache_RDY    out  1       1 only in IDLE: request can be accepted
//  Cache_VALID  out  1       one-cycle pulse: request complete
//  RDATA        out  32      load data; valid with Cache_VALID, held until next accept
//  MEM_REQ      out  1       memory request, held until MEM_ACK
//  MEM_WE       out  1       1 = memory write, 0 = read
//  MEM_ADDR     out  ADDR_W  word-aligned memory address
//  MEM_WDATA    out  32      memory write data
//  MEM_BE       out  4       memory write byte enables
//  MEM_RDATA    in   32      memory read data, valid in MEM_ACK cycle
//  MEM_ACK      in   1       one-cycle completion strobe from memory
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits cleared, Cache_RDY=1, Cache_VALID=0, RDATA=0, MEM_REQ=0, MEM_WE=0,
//   MEM_ADDR/MEM_WDATA=0, MEM_BE=0. Reset mid-operation aborts at that edge; MEM_REQ drops, partial refill discarded.
//  States: IDLE, COMPARE, REFILL, WRITE_MEM, RESP, WAIT_DROP.
//  IDLE: MemRead|MemWrite high -> latch ADDR/WDATA/BE/op, go COMPARE. Write wins if both high.
//  COMPARE: hit = valid[idx] & tag match.
//   read hit  -> RDATA <= line word, go RESP (VALID 2 cycles after accept edge).
//   read miss -> go REFILL, offset counter = 0.
//   write     -> if hit, merge WDATA bytes per BE into cached word this edge; go WRITE_MEM (hit or miss).
//  REFILL: MEM_REQ=1, MEM_WE=0, MEM_ADDR={tag,idx,cnt,2'b00}; on MEM_ACK store MEM_RDATA at word cnt,
//   capture into RDATA if cnt==requested offset; cnt++. After ACK of word LINE_WORDS-1: write tag, set valid, go RESP.
//   MEM_REQ deasserts in the cycle after each ACK (one idle cycle between refill words).
//  WRITE_MEM: MEM_REQ=1, MEM_WE=1, MEM_ADDR=latched word addr, MEM_WDATA/MEM_BE=latched; on MEM_ACK go RESP.
//   Write miss never allocates; valid/tag untouched.
//  RESP: Cache_VALID=1 for exactly this cycle; go WAIT_DROP.
//  WAIT_DROP: stay until MemRead==0 && MemWrite==0 (CPU holds request past VALID), then IDLE. Prevents re-accept.
//  MEM_ACK outside REFILL/WRITE_MEM is ignored. MEM_* outputs stable while MEM_REQ=1.
//  BE=4'b0000 store: memory write still issued; cached word unchanged.
//  Offset counter wraps at LINE_WORDS; index/tag arithmetic unsigned, no carry between fields.
// TESTING (memory model: ACK 3 cycles after MEM_REQ rises, mem word k = 0xA000_0000+k)
//  1 Reset, read 0x040 -> 4 refill reads 0x040..0x04C, VALID once, RDATA=0xA000_0010, valid[4]=1.
//  2 Read 0x048 after test 1 -> no MEM_REQ, VALID 2 cycles after accept, RDATA=0xA000_0012.
//  3 Write 0x044 WDATA=0x1122_3344 BE=4'b0011 -> one MEM write BE=0011; then read 0x044 hit = 0xA000_3344.
//  4 Write miss 0x800 -> MEM write only; following read 0x800 misses and refills (no allocate).
//  5 Hold MemRead high 5 cycles after VALID -> exactly one VALID, Cache_RDY stays 0 until request drops.
//  6 Assert RST during refill word 2 -> next cycle IDLE, MEM_REQ=0, re-read of same line misses.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the CPU-side requester, the data cache and the main-memory port.
// The slave view is the cache; the master view is its environment (CPU plus memory).
interface dcache_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    // CPU request/response
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WDATA;
    logic [3:0]        BE;
    logic              Cache_RDY;
    logic              Cache_VALID;
    logic [31:0]       RDATA;

    // Main-memory port
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [3:0]        MEM_BE;
    logic [31:0]       MEM_RDATA;
    logic              MEM_ACK;

    modport slave (
        input  MemRead, MemWrite, ADDR, WDATA, BE, MEM_RDATA, MEM_ACK,
        output Cache_RDY, Cache_VALID, RDATA, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );

    modport master (
        output MemRead, MemWrite, ADDR, WDATA, BE, MEM_RDATA, MEM_ACK,
        input  Cache_RDY, Cache_VALID, RDATA, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses refill a whole line from memory one word at a time; every store goes to memory.
module dcache_ctrl #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic          CLK,
    input logic          RST,
    dcache_ctrl_if.slave bus
);
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned NUM_WORDS = NUM_LINES * LINE_WORDS;
    localparam int unsigned WORD_W    = ADDR_W - 2;
    localparam logic [OFF_W-1:0] LastOff = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StRefill,
        StWriteMem,
        StResp,
        StWaitDrop
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   req_word_q, req_word_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [3:0]          req_be_q, req_be_d;
    logic                req_we_q, req_we_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_LINES];
    logic [TAG_W-1:0]    tag_d [NUM_LINES];
    logic [31:0]         data_q [NUM_WORDS];
    logic [31:0]         data_d [NUM_WORDS];
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;

    // Byte offset bits never matter: all accesses are whole words.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = bus.ADDR[1:0];

    // Fields of the latched request address.
    logic [OFF_W-1:0]       req_off;
    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W+OFF_W-1:0] req_sel;
    logic                   hit;

    always_comb begin
        req_off = req_word_q[OFF_W-1:0];
        req_idx = req_word_q[OFF_W +: IDX_W];
        req_tag = req_word_q[WORD_W-1 -: TAG_W];
        req_sel = {req_idx, req_off};
        hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    end

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Next-state logic for the controller FSM, the line arrays and the memory port.
    always_comb begin
        state_d     = state_q;
        req_word_d  = req_word_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        req_we_d    = req_we_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            StIdle: begin
                if (bus.MemRead || bus.MemWrite) begin
                    req_word_d  = bus.ADDR[ADDR_W-1:2];
                    req_wdata_d = bus.WDATA;
                    req_be_d    = bus.BE;
                    req_we_d    = bus.MemWrite;
                    state_d     = StCompare;
                end
            end
            StCompare: begin
                if (req_we_q) begin
                    // Write-through: update a hit in place, always send the store to memory.
                    if (hit) data_d[req_sel] = merge_be(data_q[req_sel], req_wdata_q, req_be_q);
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {req_word_q, 2'b00};
                    mem_wdata_d = req_wdata_q;
                    mem_be_d    = req_be_q;
                    state_d     = StWriteMem;
                end else if (hit) begin
                    rdata_d = data_q[req_sel];
                    state_d = StResp;
                end else begin
                    // Line is being overwritten; keep it invalid until the refill completes.
                    valid_d[req_idx] = 1'b0;
                    cnt_d            = '0;
                    mem_req_d        = 1'b1;
                    mem_we_d         = 1'b0;
                    mem_be_d         = '0;
                    mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                    state_d          = StRefill;
                end
            end
            StRefill: begin
                if (mem_req_q && bus.MEM_ACK) begin
                    data_d[{req_idx, cnt_q}] = bus.MEM_RDATA;
                    if (cnt_q == req_off) rdata_d = bus.MEM_RDATA;
                    cnt_d     = cnt_q + OFF_W'(1);
                    mem_req_d = 1'b0;
                    if (cnt_q == LastOff) begin
                        tag_d[req_idx]   = req_tag;
                        valid_d[req_idx] = 1'b1;
                        state_d          = StResp;
                    end
                end else if (!mem_req_q) begin
                    // One idle cycle after each ACK, then request the next word.
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_tag, req_idx, cnt_q, 2'b00};
                end
            end
            StWriteMem: begin
                if (mem_req_q && bus.MEM_ACK) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                state_d = StWaitDrop;
            end
            StWaitDrop: begin
                // The CPU may hold its request past VALID; do not accept it twice.
                if (!bus.MemRead && !bus.MemWrite) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; only valid bits matter for array contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_we_q    <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            valid_q     <= '0;
            tag_q       <= '{default: '0};
            data_q      <= '{default: '0};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_word_q  <= req_word_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            req_we_q    <= req_we_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Outputs straight from state and registers.
    always_comb begin
        bus.Cache_RDY   = (state_q == StIdle);
        bus.Cache_VALID = (state_q == StResp);
        bus.RDATA       = rdata_q;
        bus.MEM_REQ     = mem_req_q;
        bus.MEM_WE      = mem_we_q;
        bus.MEM_ADDR    = mem_addr_q;
        bus.MEM_WDATA   = mem_wdata_q;
        bus.MEM_BE      = mem_be_q;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: tests queue expected CPU responses and memory transactions,
// separate monitors pop and compare them when the DUT presents VALID or raises MEM_REQ.
module tb_dcache_ctrl;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if #(.ADDR_W(AW)) bus ();

    dcache_ctrl #(
        .ADDR_W    (AW),
        .NUM_LINES (8),
        .LINE_WORDS(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    be;
    } mem_txn_t;

    typedef struct {
        logic        is_rd;
        logic [31:0] rd;
        string       name;
    } resp_t;

    mem_txn_t exp_mem[$];
    resp_t    exp_rsp[$];

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int mem_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected / not seen", name);
    endfunction

    task automatic push_mem(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        mem_txn_t t;
        t.we = we; t.addr = a; t.wd = wd; t.be = be;
        exp_mem.push_back(t);
    endtask

    task automatic push_rsp(input logic is_rd, input logic [31:0] rd, input string name);
        resp_t r;
        r.is_rd = is_rd; r.rd = rd; r.name = name;
        exp_rsp.push_back(r);
    endtask

    // ---------------- memory model: ACK 3 cycles after MEM_REQ rises ----------------
    logic [31:0] mem [int];
    int          mem_busy = 0;
    int          mem_wait = 0;
    mem_txn_t    cur;
    mem_txn_t    mem_e;

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        int k;
        k = int'(a >> 2);
        if (mem.exists(k)) return mem[k];
        return 32'hA000_0000 + k;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mem_busy      = 0;
            bus.MEM_ACK   = 1'b0;
            bus.MEM_RDATA = '0;
        end else if (bus.MEM_ACK) begin
            bus.MEM_ACK = 1'b0;
            mem_busy    = 0;
        end else if (mem_busy != 0) begin
            mem_wait++;
            if (mem_wait == 3) begin
                chk("mem_addr_stable", 32'(bus.MEM_ADDR), 32'(cur.addr));
                if (cur.we) begin
                    logic [31:0] w;
                    w = mem_rd(cur.addr);
                    for (int b = 0; b < 4; b++) if (cur.be[b]) w[8*b +: 8] = cur.wd[8*b +: 8];
                    mem[int'(cur.addr >> 2)] = w;
                end else begin
                    bus.MEM_RDATA = mem_rd(cur.addr);
                end
                bus.MEM_ACK = 1'b1;
            end
        end else if (bus.MEM_REQ) begin
            mem_busy = 1;
            mem_wait = 0;
            mem_cnt++;
            cur.we   = bus.MEM_WE;
            cur.addr = bus.MEM_ADDR;
            cur.wd   = bus.MEM_WDATA;
            cur.be   = bus.MEM_BE;
            if (exp_mem.size() == 0) begin
                fail("unexpected_mem_req");
            end else begin
                mem_e = exp_mem.pop_front();
                chk("mem_we", 32'(cur.we), 32'(mem_e.we));
                chk("mem_addr", 32'(cur.addr), 32'(mem_e.addr));
                if (mem_e.we) begin
                    chk("mem_wdata", cur.wd, mem_e.wd);
                    chk("mem_be", 32'(cur.be), 32'(mem_e.be));
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    resp_t r_e;
    always @(negedge clk) begin
        if (!rst && bus.Cache_VALID) begin
            n_valid++;
            if (exp_rsp.size() == 0) begin
                fail("unexpected_valid");
            end else begin
                r_e = exp_rsp.pop_front();
                if (r_e.is_rd) chk(r_e.name, bus.RDATA, r_e.rd);
            end
        end
    end

    // ---------------- CPU-side stimulus ----------------
    // lat counts clock edges from the accept edge (inclusive) until VALID is visible.
    task automatic txn(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, output int lat);
        int guard;
        @(posedge clk); #1;
        bus.MemRead  = !we;
        bus.MemWrite = we;
        bus.ADDR     = a;
        bus.WDATA    = wd;
        bus.BE       = be;
        guard = 0;
        @(negedge clk);
        while (!bus.Cache_RDY && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.Cache_VALID && lat < 200);
        if (lat >= 200) fail("valid_timeout");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rdy_low", 32'(bus.Cache_RDY), 32'd0);
            if (bus.Cache_VALID) fail("hold_second_valid");
        end
        @(posedge clk); #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        @(posedge clk);
    endtask

    int lat;
    int c0;
    int v0;
    int guard;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ADDR     = '0;
        bus.WDATA    = '0;
        bus.BE       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(bus.Cache_RDY), 32'd1);
        chk("rst_valid", 32'(bus.Cache_VALID), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'd0);
        chk("rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
        chk("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
        chk("rst_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
        chk("rst_mem_wdata", bus.MEM_WDATA, 32'd0);
        chk("rst_mem_be", 32'(bus.MEM_BE), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: cold read miss refills line 4
        c0 = mem_cnt;
        for (int k = 0; k < 4; k++) push_mem(1'b0, 12'h040 + 12'(4 * k), '0, '0);
        push_rsp(1'b1, 32'hA000_0010, "t1_rdata");
        txn(1'b0, 12'h040, '0, '0, 0, lat);
        chk("t1_mem_reads", 32'(mem_cnt - c0), 32'd4);

        // 2: read hit in the same line
        c0 = mem_cnt;
        push_rsp(1'b1, 32'hA000_0012, "t2_rdata");
        txn(1'b0, 12'h048, '0, '0, 0, lat);
        chk("t2_hit_latency", 32'(lat), 32'd2);
        chk("t2_no_mem", 32'(mem_cnt - c0), 32'd0);

        // 3: write hit with partial byte enables, then read back
        c0 = mem_cnt;
        push_mem(1'b1, 12'h044, 32'h1122_3344, 4'b0011);
        push_rsp(1'b0, '0, "t3_wr");
        txn(1'b1, 12'h044, 32'h1122_3344, 4'b0011, 0, lat);
        chk("t3_one_write", 32'(mem_cnt - c0), 32'd1);
        push_rsp(1'b1, 32'hA000_3344, "t3_rdata");
        txn(1'b0, 12'h044, '0, '0, 0, lat);
        chk("t3_hit_latency", 32'(lat), 32'd2);

        // BE=0 store: memory write issued, cached word unchanged
        c0 = mem_cnt;
        push_mem(1'b1, 12'h048, 32'hFFFF_FFFF, 4'b0000);
        push_rsp(1'b0, '0, "tbe0_wr");
        txn(1'b1, 12'h048, 32'hFFFF_FFFF, 4'b0000, 0, lat);
        push_rsp(1'b1, 32'hA000_0012, "tbe0_rdata");
        txn(1'b0, 12'h048, '0, '0, 0, lat);
        chk("tbe0_one_write", 32'(mem_cnt - c0), 32'd1);

        // 4: write miss does not allocate; next read refills
        c0 = mem_cnt;
        push_mem(1'b1, 12'h800, 32'hDEAD_BEEF, 4'b1111);
        push_rsp(1'b0, '0, "t4_wr");
        txn(1'b1, 12'h800, 32'hDEAD_BEEF, 4'b1111, 0, lat);
        for (int k = 0; k < 4; k++) push_mem(1'b0, 12'h800 + 12'(4 * k), '0, '0);
        push_rsp(1'b1, 32'hDEAD_BEEF, "t4_rdata");
        txn(1'b0, 12'h800, '0, '0, 0, lat);
        chk("t4_mem_txns", 32'(mem_cnt - c0), 32'd5);
        push_rsp(1'b1, 32'hA000_0201, "t4_hit_rdata");
        txn(1'b0, 12'h804, '0, '0, 0, lat);
        chk("t4_hit_latency", 32'(lat), 32'd2);

        // 5: request held past VALID yields exactly one response
        v0 = n_valid;
        push_rsp(1'b1, 32'hA000_0013, "t5_rdata");
        txn(1'b0, 12'h04C, '0, '0, 5, lat);
        chk("t5_one_valid", 32'(n_valid - v0), 32'd1);
        @(negedge clk);
        chk("t5_rdy_after_drop", 32'(bus.Cache_RDY), 32'd1);

        // 6: reset during refill word 2 aborts the refill
        for (int k = 0; k < 4; k++) push_mem(1'b0, 12'h020 + 12'(4 * k), '0, '0);
        push_rsp(1'b1, 32'hA000_0008, "t6_aborted");
        @(posedge clk); #1;
        bus.MemRead = 1'b1;
        bus.ADDR    = 12'h020;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.MEM_REQ && bus.MEM_ADDR == 12'h028) && guard < 200);
        if (guard >= 200) fail("t6_word2_timeout");
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_mem.delete();
        exp_rsp.delete();
        @(negedge clk);
        chk("t6_rdy_idle", 32'(bus.Cache_RDY), 32'd1);
        chk("t6_mem_req_low", 32'(bus.MEM_REQ), 32'd0);
        chk("t6_valid_low", 32'(bus.Cache_VALID), 32'd0);
        c0 = mem_cnt;
        for (int k = 0; k < 4; k++) push_mem(1'b0, 12'h020 + 12'(4 * k), '0, '0);
        push_rsp(1'b1, 32'hA000_0008, "t6_reread_rdata");
        txn(1'b0, 12'h020, '0, '0, 0, lat);
        chk("t6_reread_misses", 32'(mem_cnt - c0), 32'd4);
        push_rsp(1'b1, 32'hA000_0009, "t6_hit_rdata");
        txn(1'b0, 12'h024, '0, '0, 0, lat);
        chk("t6_hit_latency", 32'(lat), 32'd2);

        repeat (4) @(posedge clk);
        chk("final_rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        chk("final_mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
